// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_sel encodings, bit-period helper and the
// receiver state encoding.
package uart_pkg;

  localparam logic [1:0] BAUD_9600  = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_38400 = 2'b10;
  localparam logic [1:0] BAUD_57600 = 2'b11;

  localparam int CNT_W = 13;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per bit, truncated; must fit the 13-bit bit counter.
  function automatic logic [CNT_W-1:0] cpb(input logic [1:0] sel, input int clk_freq_hz);
    int baud;
    baud = 9600;
    case (sel)
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      BAUD_38400: baud = 38400;
      BAUD_57600: baud = 57600;
      default:    baud = 9600;
    endcase
    return CNT_W'(clk_freq_hz / baud);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line; resets to the
// idle (high) level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [STAGES-1:0] sync_q;

  // NOTE: flops are written with <= so every stage samples the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], rx};
  end

  assign rx_s = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, baud chosen per frame from baud_sel,
// valid/ready byte delivery with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] baud_sel,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  import uart_pkg::*;

  logic             rx_s;
  rx_state_e        state;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             commit_q;
  logic [CNT_W-1:0] cpb_m1;
  logic [CNT_W-1:0] half_m1;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // Timing follows the rate latched at frame start, not the live baud_sel.
  assign cpb_m1  = cpb(sel_q, CLK_FREQ_HZ) - CNT_W'(1);
  assign half_m1 = (cpb(sel_q, CLK_FREQ_HZ) >> 1) - CNT_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= BAUD_9600;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      commit_q  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      commit_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            sel_q <= baud_sel;
          end
        end
        START: begin
          if (cnt == half_m1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == cpb_m1) begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit gives half a bit to spot a back-to-back start.
          if (cnt == cpb_m1) begin
            cnt <= '0;
            if (rx_s) begin
              commit_q <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A same-cycle accept frees the holding register, so a commit then succeeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_q && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (commit_q) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand sequences for
// overrun, glitch, break, mid-frame rate change and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

  // Scaled clock keeps frames short; bit periods below are hand-computed.
  localparam int CLK_HZ = 5_000_000;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] baud_sel;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         valid_rises = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  always #10 clk = ~clk;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .baud_sel  (baud_sel),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) begin
      valid_rises <= valid_rises + 1;
      last_data   <= rx_data;
      rise_cyc    <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  // 5 MHz / {9600,19200,38400,57600}, truncated.
  function automatic int cpb_of(input logic [1:0] s);
    case (s)
      2'b00:   return 520;
      2'b01:   return 260;
      2'b10:   return 130;
      default: return 86;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling clock edge; drives one 8N1 frame at c clocks per bit.
  task automatic send_frame(input logic [7:0] d, input int c, input logic stop_bit,
                            input int extra_low);
    rx = 1'b0;
    start_cyc = cyc;
    idle(c);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(c);
    end
    rx = stop_bit;
    idle(c);
    if (extra_low > 0) begin
      rx = 1'b0;
      idle(extra_low);
    end
    rx = 1'b1;
  endtask

  task automatic check_latency(input string name, input logic [1:0] s);
    int c;
    int exp_lat;
    c = cpb_of(s);
    exp_lat = SYNC + c / 2 + 9 * c + 1;
    check_range(name, rise_cyc - start_cyc, exp_lat - 1, exp_lat + 2);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, f0, o0;

    vecs[0] = '{2'b11, 8'hA5, 1'b1, 1, 0};
    vecs[1] = '{2'b10, 8'h3C, 1'b1, 1, 0};
    vecs[2] = '{2'b01, 8'h81, 1'b1, 1, 0};
    vecs[3] = '{2'b00, 8'h5A, 1'b1, 1, 0};
    vecs[4] = '{2'b11, 8'h00, 1'b1, 1, 0};
    vecs[5] = '{2'b11, 8'hFF, 1'b1, 1, 0};
    vecs[6] = '{2'b10, 8'h66, 1'b0, 0, 1};

    rst = 1'b1;
    rx = 1'b1;
    baud_sel = 2'b11;
    rx_ready = 1'b1;
    idle(3);
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      baud_sel = vecs[i].sel;
      idle(2);
      v0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[i].data, cpb_of(vecs[i].sel), vecs[i].stop_bit, 0);
      idle(cpb_of(vecs[i].sel));
      check($sformatf("vec%0d valid count", i), valid_rises - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d frame_err count", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun count", i), ovr_cnt - o0, 0);
      check($sformatf("vec%0d busy after", i), busy, 0);
      if (vecs[i].exp_valid != 0) begin
        check($sformatf("vec%0d rx_data", i), last_data, vecs[i].data);
        check_latency($sformatf("vec%0d latency", i), vecs[i].sel);
      end
    end

    // Back-to-back at 9600 with consumer stalled: second byte overruns.
    baud_sel = 2'b00;
    rx_ready = 1'b0;
    idle(10);
    v0 = valid_rises; o0 = ovr_cnt;
    send_frame(8'h00, 520, 1'b1, 0);
    send_frame(8'hFF, 520, 1'b1, 0);
    idle(20);
    check("b2b valid count", valid_rises - v0, 1);
    check("b2b held data", rx_data, 8'h00);
    check("b2b valid held", rx_valid, 1);
    check("b2b overrun count", ovr_cnt - o0, 1);
    rx_ready = 1'b1;
    idle(2);
    check("b2b valid drops", rx_valid, 0);
    idle(50);
    check("b2b second not delivered", valid_rises - v0, 1);

    // 20-clock glitch at 38400 (half-bit 65 clocks) is rejected.
    baud_sel = 2'b10;
    idle(10);
    v0 = valid_rises; f0 = ferr_cnt;
    rx = 1'b0;
    idle(5);
    check("glitch busy", busy, 1);
    idle(15);
    rx = 1'b1;
    idle(75);
    check("glitch busy cleared", busy, 0);
    check("glitch no valid", valid_rises - v0, 0);
    check("glitch no frame_err", ferr_cnt - f0, 0);

    // Framing error followed by a break: one frame_err, then recovery.
    baud_sel = 2'b01;
    idle(10);
    v0 = valid_rises; f0 = ferr_cnt;
    send_frame(8'h3C, 260, 1'b0, 5 * 260);
    idle(520);
    check("break frame_err count", ferr_cnt - f0, 1);
    check("break no valid", valid_rises - v0, 0);
    send_frame(8'h81, 260, 1'b1, 0);
    idle(260);
    check("post-break valid count", valid_rises - v0, 1);
    check("post-break data", last_data, 8'h81);

    // baud_sel change mid-frame only affects the next frame.
    baud_sel = 2'b00;
    idle(10);
    v0 = valid_rises;
    fork
      send_frame(8'h5A, 520, 1'b1, 0);
      begin
        idle(5 * 520);
        baud_sel = 2'b11;
      end
    join
    idle(100);
    check("rate change old frame count", valid_rises - v0, 1);
    check("rate change old frame data", last_data, 8'h5A);
    send_frame(8'hE7, 86, 1'b1, 0);
    idle(86);
    check("rate change new frame count", valid_rises - v0, 2);
    check("rate change new frame data", last_data, 8'hE7);
    check_latency("rate change new latency", 2'b11);

    // Reset during data bit 4 of a 57600 frame.
    idle(10);
    rx = 1'b0;
    idle(86);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(86);
    end
    rx = 1'b1;
    idle(40);
    check("pre-reset busy", busy, 1);
    v0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
    rst = 1'b1;
    #1;
    check("midreset rx_data", rx_data, 0);
    check("midreset rx_valid", rx_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset frame_err", frame_err, 0);
    check("midreset overrun", overrun, 0);
    idle(3);
    rst = 1'b0;
    idle(200);
    check("post-reset no valid", valid_rises - v0, 0);
    send_frame(8'hC3, 86, 1'b1, 0);
    idle(86);
    check("post-reset valid count", valid_rises - v0, 1);
    check("post-reset data", last_data, 8'hC3);
    check("post-reset no flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
